// File: rtl/tinker_pkg.sv
// Shared Tinker ISA definitions: opcodes, instruction field layout,
// encoder FSM states and the field-tuple struct.
package tinker_pkg;

  // Opcodes (subset the loader and assembler refer to by name)
  localparam logic [4:0] OP_AND   = 5'h00;
  localparam logic [4:0] OP_OR    = 5'h01;
  localparam logic [4:0] OP_XOR   = 5'h02;
  localparam logic [4:0] OP_NOT   = 5'h03;
  localparam logic [4:0] OP_BR    = 5'h08;
  localparam logic [4:0] OP_CALL  = 5'h0C;
  localparam logic [4:0] OP_RET   = 5'h0D;
  localparam logic [4:0] OP_PRIV  = 5'h0F;
  localparam logic [4:0] OP_ADD   = 5'h18;
  localparam logic [4:0] OP_ADDI  = 5'h19;
  localparam logic [4:0] OP_SUB   = 5'h1A;
  localparam logic [4:0] OP_SUBI  = 5'h1B;
  localparam logic [4:0] OP_MUL   = 5'h1C;
  localparam logic [4:0] OP_DIV   = 5'h1D;
  localparam logic [4:0] OPC_MAX  = 5'h1D;  // highest legal opcode

  // Field widths and bit positions inside the 32-bit instruction word
  localparam int unsigned REG_W   = 5;
  localparam int unsigned LIT_W   = 12;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RD_LSB  = 22;
  localparam int unsigned RS_LSB  = 17;
  localparam int unsigned RT_LSB  = 12;
  localparam int unsigned LIT_LSB = 0;

  // Encoder FSM: idle, then one state per byte of the word (LSB first)
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR0  = 3'd1,
    ST_WR1  = 3'd2,
    ST_WR2  = 3'd3,
    ST_WR3  = 3'd4
  } enc_state_e;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [11:0] literal;
  } tinker_fields_t;

endpackage

// File: rtl/tinker_instr_encoder_if.sv
// Field-tuple input handshake plus byte-wide instruction-memory write port.
interface tinker_instr_encoder_if;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [11:0] in_literal;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        illegal;
  logic        full;
  logic [15:0] count;

  // Loader / test-harness side
  modport master (
    output clear, in_valid, in_opcode, in_rd, in_rs, in_rt, in_literal,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, illegal, full, count
  );

  // Encoder side
  modport slave (
    input  clear, in_valid, in_opcode, in_rd, in_rs, in_rt, in_literal,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, illegal, full, count
  );
endinterface

// File: rtl/tinker_field_pack.sv
// Combinational packer: field tuple -> 32-bit Tinker word plus legal flag.
module tinker_field_pack
  import tinker_pkg::*;
(
  input  tinker_fields_t fields_i,
  output logic [31:0]    word_o,
  output logic           legal_o
);

  // Place each field at its bit position and flag reserved opcodes
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    word_o                      = '0;
    word_o[OPC_LSB +: REG_W]    = fields_i.opcode;
    word_o[RD_LSB  +: REG_W]    = fields_i.rd;
    word_o[RS_LSB  +: REG_W]    = fields_i.rs;
    word_o[RT_LSB  +: REG_W]    = fields_i.rt;
    word_o[LIT_LSB +: LIT_W]    = fields_i.literal;
    legal_o                     = (fields_i.opcode <= OPC_MAX);
  end

endmodule

// File: rtl/tinker_instr_encoder.sv
// Accepts Tinker field tuples and writes each packed word little-endian,
// one byte per cycle, at an incrementing code address.
module tinker_instr_encoder
  import tinker_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter logic [31:0] LIMIT_ADDR = 32'h0008_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  tinker_instr_encoder_if.slave  bus
);

  enc_state_e     state_q, state_d;
  logic [31:0]    ptr_q, ptr_d;
  logic [15:0]    count_q, count_d;
  logic [31:0]    word_q, word_d;
  logic           mem_we_q, mem_we_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [7:0]     mem_wdata_q, mem_wdata_d;
  logic           illegal_q, illegal_d;
  logic           busy_q, busy_d;

  tinker_fields_t fields;
  logic [31:0]    packed_word;
  logic           legal;
  logic [32:0]    ptr_end;
  logic           full;
  logic           in_ready;

  assign fields = {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_rt, bus.in_literal};

  tinker_field_pack u_pack (
    .fields_i (fields),
    .word_o   (packed_word),
    .legal_o  (legal)
  );

  // 33-bit compare so a pointer near 2^32 cannot wrap into "not full"
  assign ptr_end  = {1'b0, ptr_q} + 33'd4;
  assign full     = (ptr_end > {1'b0, LIMIT_ADDR});
  assign in_ready = (state_q == ST_IDLE) && !full && !bus.clear;

  // Next-state, pointer/count update and registered-output precompute
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    illegal_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.clear) begin
          ptr_d   = BASE_ADDR;
          count_d = '0;
        end else if (bus.in_valid && in_ready) begin
          if (legal) begin
            word_d      = packed_word;
            state_d     = ST_WR0;
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = packed_word[7:0];
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_WR0: begin
        state_d     = ST_WR1;
        mem_we_d    = 1'b1;
        mem_addr_d  = ptr_q + 32'd1;
        mem_wdata_d = word_q[15:8];
      end
      ST_WR1: begin
        state_d     = ST_WR2;
        mem_we_d    = 1'b1;
        mem_addr_d  = ptr_q + 32'd2;
        mem_wdata_d = word_q[23:16];
      end
      ST_WR2: begin
        state_d     = ST_WR3;
        mem_we_d    = 1'b1;
        mem_addr_d  = ptr_q + 32'd3;
        mem_wdata_d = word_q[31:24];
      end
      ST_WR3: begin
        state_d = ST_IDLE;
        ptr_d   = ptr_q + 32'd4;
        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any partial word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= BASE_ADDR;
      count_q     <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.full      = full;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.illegal   = illegal_q;
  assign bus.busy      = busy_q;
  assign bus.count     = count_q;

endmodule

// File: doc/tinker_instr_encoder.md
# tinker_instr_encoder

Packs Tinker instruction fields into 32-bit instruction words and streams them into byte-addressed instruction memory. This block is the write-side counterpart of the instruction decoder: a boot/loader path or test harness hands it field tuples, and it writes little-endian words at an incrementing code address starting at the program base. It rejects illegal opcodes, tracks how many words it has written, and stops accepting input when the code region is full.

## Interface
- BASE_ADDR, 32'h0000_2000, first code byte address; pointer value after reset or clear
- LIMIT_ADDR, 32'h0008_0000, exclusive upper bound of the code region
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous pointer/count restart; honoured only in IDLE
- in_valid  input  1  field tuple valid
- in_ready  output  1  encoder can accept a tuple
- in_opcode  input  5  opcode field
- in_rd / in_rs / in_rt  input  5 each  register fields
- in_literal  input  12  literal field
- mem_we  output  1  byte write strobe
- mem_addr  output  32  byte address
- mem_wdata  output  8  byte data
- busy  output  1  word write in progress
- illegal  output  1  one-cycle pulse: rejected opcode
- full  output  1  next word would cross LIMIT_ADDR
- count  output  16  words written since reset/clear

## Operation
- Word packing: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], literal[11:0]; no field masking beyond widths.
- Legal opcodes are 5'h00–5'h1D; 5'h1E and 5'h1F are illegal.
- FSM states: IDLE, WR0, WR1, WR2, WR3.
- IDLE: in_ready = !full && !clear. On in_valid && in_ready:
  - legal: latch word, go to WR0.
  - illegal: stay in IDLE, pulse illegal next cycle, no write, pointer/count unchanged.
- WRn (n = 0..3): mem_we=1, mem_addr=ptr+n, mem_wdata=word[8n+7:8n], so the LSB is written first. WR3 → IDLE with ptr += 4 and count += 1, both taking effect in that transition.
- full = (ptr + 4 > LIMIT_ADDR), evaluated in 33-bit arithmetic so it does not wrap. It is combinational from ptr.
- clear in IDLE: ptr ← BASE_ADDR, count ← 0. clear has priority over in_valid.
  - clear during WRn is ignored; hold it until the block returns to IDLE.
- count saturates at 16'hFFFF while writes continue.
- Reset values: state IDLE, ptr BASE_ADDR, count 0, mem_we 0, mem_addr 0, mem_wdata 0, illegal 0, busy 0. in_ready is 1 out of reset unless BASE_ADDR+4 > LIMIT_ADDR.

## Timing
- All outputs are registered except in_ready and full, which decode from state and ptr.
- A legal handshake at edge N produces byte writes in cycles N+1..N+4. in_ready is high again in cycle N+5.
  - Sustained throughput: one word per 5 cycles.
- An illegal handshake at edge N asserts illegal in cycle N+1 only. in_ready stays high, so back-to-back illegal tuples are accepted every cycle.
- busy = 1 exactly in WR0..WR3.
- Asserting reset_n low mid-word drops mem_we and all outputs immediately (asynchronously). The partial word is abandoned and the next word restarts at BASE_ADDR.
- When the last word that fits finishes (WR3 → IDLE), full rises in the same cycle that state becomes IDLE, so no handshake is possible.

## Structure
- tinker_pkg holds:
  - opcode localparams, including OP_ADD=5'h18, OP_ADDI=5'h19, and OPC_MAX=5'h1D
  - field bit-position constants
  - the fsm state enum
  - the tinker_fields_t packed struct {opcode, rd, rs, rt, literal}
- One sub-module, tinker_field_pack: combinational struct → 32-bit word plus a legal flag. It is shared with future assembler/test logic.

## Test plan
- ADD r1,r2,r3 (opcode 18, rd 1, rs 2, rt 3, literal 0) after reset → word 32'hC0443000; bytes 00,30,44,C0 at 0x2000–0x2003 in consecutive cycles; count=1.
- ADDI r1,r0,0x03F immediately after the ADD → word 32'hC840003F; bytes 3F,00,40,C8 at 0x2004–0x2007; in_ready low for exactly 4 cycles per word; count=2.
- Opcode 5'h1F → illegal pulses one cycle, no mem_we, count and ptr unchanged; the next legal tuple is written to the unchanged ptr.
- LIMIT_ADDR=32'h2008: after two words full=1 and in_ready=0; a held in_valid is never accepted; clear → full=0, ptr=0x2000, count=0.
- reset_n asserted after the second byte of a word → mem_we 0 within the same cycle; after release, a new word is written at 0x2000 and count=1.
- clear held during WR1 → ignored until IDLE; applied on the first IDLE cycle, and in_valid asserted in that cycle is not accepted.
